// File: rtl/le_pkg.sv
`default_nettype none
// ============================================================================
// Module      : le_pkg
// Description : Shared width, function-select and slot-state definitions for
//               the LE logic unit and its arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package le_pkg;

    localparam int W = 4;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_XOR = 2'b10;
    localparam logic [1:0] SEL_NOT = 2'b11;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/LE.sv
`default_nettype none
// ============================================================================
// Module      : LE
// Description : 4-bit bitwise logic unit (AND / OR / XOR / NOT A).
// Revision    : 1.0 - initial release
// ============================================================================
module LE
    import le_pkg::*;
#(
    parameter int W = le_pkg::W
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [1:0]   Sel,
    output logic [W-1:0] E
);

    always_comb begin
        E = '0;
        case (Sel)
            SEL_AND: E = A & B;
            SEL_OR:  E = A | B;
            SEL_XOR: E = A ^ B;
            SEL_NOT: E = ~A;
            default: E = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/le_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : le_arbiter
// Description : Round-robin two-requester arbiter driving one shared LE, with
//               a single registered result slot behind a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module le_arbiter
    import le_pkg::*;
#(
    parameter int W = le_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_A,
    input  logic [W-1:0] req0_B,
    input  logic [1:0]   req0_Sel,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_A,
    input  logic [W-1:0] req1_B,
    input  logic [1:0]   req1_Sel,
    output logic         req1_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_E,
    output logic         out_tag,
    output logic [1:0]   out_Sel
);

    slot_t        r_state;
    slot_t        w_state_nxt;
    logic         r_prio;
    logic         w_can_accept;
    logic         w_grant0;
    logic         w_grant1;
    logic         w_xfer;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [1:0]   w_sel;
    logic [W-1:0] w_e;

    // Grants are suppressed during reset so nothing is accepted in that cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_can_accept = !rst && ((r_state == SLOT_EMPTY) || out_ready);
        w_grant0     = w_can_accept && req0_valid && (!req1_valid || !r_prio);
        w_grant1     = w_can_accept && req1_valid && (!req0_valid ||  r_prio);
        w_xfer       = w_grant0 || w_grant1;

        case (r_state)
            SLOT_EMPTY: if (w_xfer) w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (out_ready && !w_xfer) w_state_nxt = SLOT_EMPTY;
            default:    w_state_nxt = SLOT_EMPTY;
        endcase
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign out_valid  = (r_state == SLOT_FULL);

    assign w_a   = w_grant1 ? req1_A   : req0_A;
    assign w_b   = w_grant1 ? req1_B   : req0_B;
    assign w_sel = w_grant1 ? req1_Sel : req0_Sel;

    LE #(
        .W   (W)
    ) u_le (
        .A   (w_a),
        .B   (w_b),
        .Sel (w_sel),
        .E   (w_e)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result registers and priority only move on a transfer; otherwise they hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_E   <= '0;
            out_tag <= 1'b0;
            out_Sel <= 2'b00;
            r_prio  <= 1'b0;
        end else if (w_xfer) begin
            out_E   <= w_e;
            out_tag <= w_grant1;
            out_Sel <= w_sel;
            r_prio  <= w_grant0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_le_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_le_arbiter
// Description : Self-checking bench for le_arbiter: directed scenarios plus a
//               randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_le_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_A, req0_B, req1_A, req1_B;
    logic [1:0] req0_Sel, req1_Sel;
    logic       req0_ready, req1_ready;
    logic       out_valid, out_ready;
    logic [3:0] out_E;
    logic       out_tag;
    logic [1:0] out_Sel;

    int checks;
    int failures;

    // Reference model: contents of the result slot and the round-robin pointer.
    bit         m_full;
    logic [3:0] m_E;
    bit         m_tag;
    logic [1:0] m_sel;
    bit         m_prio;

    le_arbiter #(.W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_A     (req0_A),
        .req0_B     (req0_B),
        .req0_Sel   (req0_Sel),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_A     (req1_A),
        .req1_B     (req1_B),
        .req1_Sel   (req1_Sel),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_E      (out_E),
        .out_tag    (out_tag),
        .out_Sel    (out_Sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] le_ref(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] s);
        case (s)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Which requester should win this cycle: -1 none, else its index.
    function automatic int exp_grant();
        if (rst) return -1;
        if (m_full && !out_ready) return -1;
        if (req0_valid && req1_valid) return int'(m_prio);
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic tick();
        int g;
        g = exp_grant();
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_E = 4'h0; m_tag = 0; m_sel = 2'b00; m_prio = 0;
        end else if (g == 0) begin
            m_full = 1; m_E = le_ref(req0_A, req0_B, req0_Sel);
            m_tag = 0; m_sel = req0_Sel; m_prio = 1;
        end else if (g == 1) begin
            m_full = 1; m_E = le_ref(req1_A, req1_B, req1_Sel);
            m_tag = 1; m_sel = req1_Sel; m_prio = 0;
        end else if (out_ready) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0; out_ready = 1;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; req0_valid = 1; req1_valid = 1; out_ready = 1;
        req0_A = 4'h5; req0_B = 4'h3; req0_Sel = 2'd0;
        req1_A = 4'h5; req1_B = 4'h3; req1_Sel = 2'd1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_E !== 4'h0 || out_tag !== 1'b0 || out_Sel !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b E=%h tag=%b sel=%b want v=0 E=0 tag=0 sel=0",
                     out_valid, out_E, out_tag, out_Sel);
        end
        rst = 0; req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_all_functions();
        logic [3:0] exp_e [4];
        exp_e = '{4'h1, 4'h7, 4'h6, 4'hA};
        do_reset();
        req0_valid = 1; req0_A = 4'h5; req0_B = 4'h3;
        for (int i = 0; i < 4; i++) begin
            req0_Sel = 2'(i);
            #1;
            checks++;
            if (req0_ready !== 1'b1) begin
                failures++;
                $display("FAIL func_ready[%0d]: got %b want 1", i, req0_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_E !== exp_e[i] || out_tag !== 1'b0) begin
                failures++;
                $display("FAIL func_result[%0d]: got v=%b E=%h tag=%b want v=1 E=%h tag=0",
                         i, out_valid, out_E, out_tag, exp_e[i]);
            end
        end
        req0_valid = 0;
        tick();
    endtask

    task automatic test_fairness();
        do_reset();
        req0_valid = 1; req0_A = 4'hF; req0_B = 4'h0; req0_Sel = 2'b01;
        req1_valid = 1; req1_A = 4'hC; req1_B = 4'hA; req1_Sel = 2'b10;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                failures++;
                $display("FAIL fair_grant[%0d]: got %b%b want %b%b", i, req0_ready, req1_ready,
                         (i % 2 == 0), (i % 2 == 1));
            end
            tick();
            checks++;
            if (out_tag !== (i % 2 == 1) || out_E !== ((i % 2 == 1) ? 4'h6 : 4'hF)) begin
                failures++;
                $display("FAIL fair_result[%0d]: got E=%h tag=%b want E=%h tag=%0d", i, out_E,
                         out_tag, ((i % 2 == 1) ? 4'h6 : 4'hF), i % 2);
            end
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_valid = 1; req0_A = 4'h9; req0_B = 4'h3; req0_Sel = 2'b00;
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_A = 4'hC; req1_B = 4'hA; req1_Sel = 2'b10;
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready[%0d]: got %b%b want 00", i, req0_ready, req1_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_E !== 4'h1 || out_tag !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got v=%b E=%h tag=%b want v=1 E=1 tag=0",
                         i, out_valid, out_E, out_tag);
            end
        end
        out_ready = 1;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_release_grant: got %b%b want 01", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_E !== 4'h6 || out_tag !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_result: got v=%b E=%h tag=%b want v=1 E=6 tag=1",
                     out_valid, out_E, out_tag);
        end
        req1_valid = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_drain_refill();
        do_reset();
        req0_valid = 1; req0_A = 4'hF; req0_B = 4'h0; req0_Sel = 2'b01;
        tick();
        req0_A = 4'h3; req0_B = 4'h5; req0_Sel = 2'b10;
        #1;
        checks++;
        if (out_valid !== 1'b1 || req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL refill_ready: got v=%b rdy=%b want v=1 rdy=1", out_valid, req0_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_E !== 4'h6 || out_Sel !== 2'b10) begin
            failures++;
            $display("FAIL refill_result: got v=%b E=%h sel=%b want v=1 E=6 sel=10",
                     out_valid, out_E, out_Sel);
        end
        req0_valid = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_valid = 1; req0_A = 4'hF; req0_B = 4'h0; req0_Sel = 2'b01;
        req1_valid = 1; req1_A = 4'hC; req1_B = 4'hA; req1_Sel = 2'b10;
        tick();
        rst = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_valid: got %b want 0", out_valid);
        end
        rst = 0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_first_grant: got %b%b want 10", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 1'b0 || out_E !== 4'hF) begin
            failures++;
            $display("FAIL midrst_result: got v=%b E=%h tag=%b want v=1 E=f tag=0",
                     out_valid, out_E, out_tag);
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_not_ignores_b();
        do_reset();
        req1_valid = 1; req1_A = 4'h5; req1_B = 4'hF; req1_Sel = 2'b11;
        tick();
        checks++;
        if (out_E !== 4'hA || out_Sel !== 2'b11 || out_tag !== 1'b1) begin
            failures++;
            $display("FAIL not_result: got E=%h sel=%b tag=%b want E=a sel=11 tag=1",
                     out_E, out_Sel, out_tag);
        end
        req1_valid = 0;
    endtask

    task automatic test_random();
        int g;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 39) == 0);
            req0_valid = $urandom_range(0, 1);
            req1_valid = $urandom_range(0, 1);
            out_ready  = ($urandom_range(0, 3) != 0);
            req0_A = 4'($urandom); req0_B = 4'($urandom); req0_Sel = 2'($urandom);
            req1_A = 4'($urandom); req1_B = 4'($urandom); req1_Sel = 2'($urandom);
            #1;
            g = exp_grant();
            checks++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                failures++;
                $display("FAIL rand_grant[%0d]: got %b%b want %b%b", i, req0_ready, req1_ready,
                         (g == 0), (g == 1));
            end
            tick();
            checks++;
            if (out_valid !== m_full || out_E !== m_E || out_tag !== m_tag || out_Sel !== m_sel) begin
                failures++;
                $display("FAIL rand_out[%0d]: got v=%b E=%h tag=%b sel=%b want v=%b E=%h tag=%b sel=%b",
                         i, out_valid, out_E, out_tag, out_Sel, m_full, m_E, m_tag, m_sel);
            end
        end
        rst = 0; req0_valid = 0; req1_valid = 0; out_ready = 1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_full = 0; m_E = 4'h0; m_tag = 0; m_sel = 2'b00; m_prio = 0;
        test_reset();
        test_all_functions();
        test_fairness();
        test_backpressure();
        test_drain_refill();
        test_reset_mid();
        test_not_ignores_b();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
